// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave: frame width, synchronizer depth and
// the width of the bit counter that walks through one frame.
package spi_pkg;

  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = $clog2(DATA_W);

endpackage

// File: rtl/spi_sync.sv
// N-flop synchronizer for one asynchronous SPI pin, with rise/fall pulses
// derived from the synchronized level. STAGES must be at least 2.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the pin through the synchronizer chain and keep one extra flop of
  // history for edge detection; reset to the pin's idle level so that no
  // spurious edge is reported when reset releases.
  // NOTE: non-blocking assignments let each flop sample the previous value of
  // its neighbour, which is what makes this a shift chain rather than a wire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o =  sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_com.sv
// SPI mode-0 slave, fully oversampled in the clk domain. Received frames
// appear on data_in with a one-cycle data_valid strobe; data_out is shifted
// back to the master MSB first, reloaded at every frame boundary.
module spi_com
  import spi_pkg::*;
#(
  parameter int DATA_W      = spi_pkg::DATA_W,
  parameter int SYNC_STAGES = spi_pkg::SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCK,
  input  logic              SIMO,
  input  logic              CS,
  output logic              SOMI,
  output logic [DATA_W-1:0] data_in,
  output logic              data_valid,
  input  logic [DATA_W-1:0] data_out
);

  localparam int                BIT_CNT_W = $clog2(DATA_W);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic simo_lvl, simo_rise, simo_fall;

  // SCK and SIMO idle low, CS idles high (deselected).
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d_i(SCK),
    .q_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d_i(CS),
    .q_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  // SIMO goes through the same depth so its level lines up with SCK edges.
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_simo (
    .clk(clk), .rst(rst), .d_i(SIMO),
    .q_o(simo_lvl), .rise_o(simo_rise), .fall_o(simo_fall)
  );

  // Only edges of SCK and the level of SIMO matter; CS deselection is handled
  // by level, which already covers the rising edge.
  logic unused_sync;
  assign unused_sync = &{1'b0, sck_lvl, cs_rise, simo_rise, simo_fall};

  logic                 selected;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]    rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]    tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]    data_in_q, data_in_d;
  logic                 valid_q, valid_d;
  logic                 oe_q, oe_d;

  assign selected = ~cs_lvl;

  // Next-state logic for the frame: load on select, sample on SCK rise,
  // shift or reload on SCK fall, clear everything while deselected.
  // NOTE: every signal gets a default at the top, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    data_in_d  = data_in_q;
    valid_d    = 1'b0;
    oe_d       = oe_q;

    if (cs_fall) begin
      tx_shift_d = data_out;
      rx_shift_d = '0;
      cnt_d      = '0;
      oe_d       = 1'b1;
    end else if (!selected) begin
      // Deselected or aborted mid-frame: drop any partial byte.
      rx_shift_d = '0;
      cnt_d      = '0;
      oe_d       = 1'b0;
    end else if (sck_rise) begin
      rx_shift_d = {rx_shift_q[DATA_W-2:0], simo_lvl};
      if (cnt_q == LAST_BIT) begin
        cnt_d     = '0;
        data_in_d = {rx_shift_q[DATA_W-2:0], simo_lvl};
        valid_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (sck_fall) begin
      // Counter at 0 on a falling edge means a byte just finished: fetch the
      // next one so back-to-back frames need no gap.
      if (cnt_q == '0) begin
        tx_shift_d = data_out;
      end else begin
        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Frame state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      data_in_q  <= '0;
      valid_q    <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      data_in_q  <= data_in_d;
      valid_q    <= valid_d;
      oe_q       <= oe_d;
    end
  end

  assign data_in    = data_in_q;
  assign data_valid = valid_q;
  assign SOMI       = oe_q ? tx_shift_q[DATA_W-1] : 1'bz;

endmodule

// File: tb/tb_spi_com.sv
// Bench for spi_com: acts as an SPI mode-0 master, keeps a queue of bytes the
// slave should deliver and compares against the data_valid strobes it sees.
module tb_spi_com;

  logic       clk = 1'b0;
  logic       rst;
  logic       SCK, SIMO, CS;
  logic [7:0] data_out;
  logic [7:0] data_in;
  logic       data_valid;
  wire        somi_w;

  // Released SOMI reads as 1; the slave's reset/idle shift data is 0, so a
  // wrongly driven line reads differently from a released one.
  pullup (somi_w);

  spi_com dut (
    .clk       (clk),
    .rst       (rst),
    .SCK       (SCK),
    .SIMO      (SIMO),
    .CS        (CS),
    .SOMI      (somi_w),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: every completed byte the master sends must come out once.
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] model_data_in;
  logic       valid_prev = 1'b0;
  int         wide_pulses = 0;

  always @(negedge clk) begin
    if (data_valid === 1'b1) got_q.push_back(data_in);
    if (data_valid === 1'b1 && valid_prev) wide_pulses++;
    valid_prev = (data_valid === 1'b1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One CS-low window of nbits SCK cycles (SCK = clk/8). mosi/miso hold up to
  // two bytes, first byte in the upper half.
  task automatic frame(input logic [15:0] mosi, input logic [15:0] miso,
                       input int nbits, input logic [7:0] next_out);
    logic [15:0] somi_got;
    somi_got = '0;
    @(negedge clk);
    CS = 1'b0;
    data_out = miso[15:8];
    wait_clk(8);
    for (int b = 0; b < nbits; b++) begin
      int i;
      int k;
      logic [7:0] mb;
      i  = b / 8;
      k  = 7 - (b % 8);
      mb = (i == 0) ? mosi[15:8] : mosi[7:0];
      SIMO = mb[k];
      if (k == 0) data_out = (i == 0 && nbits > 8) ? miso[7:0] : next_out;
      wait_clk(4);
      SCK = 1'b1;
      somi_got = {somi_got[14:0], somi_w};
      if (k == 0) begin
        exp_q.push_back(mb);
        model_data_in = mb;
      end
      wait_clk(4);
      SCK = 1'b0;
    end
    check("somi_bits", {16'h0, somi_got}, {16'h0, miso >> (16 - nbits)});
    wait_clk(4);
    CS = 1'b1;
    wait_clk(8);
  endtask

  task automatic drain(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({name, "_byte"}, {24'h0, got_q.pop_front()}, {24'h0, exp_q.pop_front()});
    exp_q.delete();
    got_q.delete();
    check({name, "_data_in"}, {24'h0, data_in}, {24'h0, model_data_in});
  endtask

  typedef struct {
    string       name;
    logic [15:0] mosi;
    logic [15:0] miso;
    int          nbits;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"single",      16'hA500, 16'hBB00,  8, 1};
    vecs[1] = '{"b2b",         16'h3CC3, 16'h1122, 16, 2};
    vecs[2] = '{"abort",       16'hF000, 16'h7700,  4, 0};
    vecs[3] = '{"after_abort", 16'h0F00, 16'h9600,  8, 1};
    vecs[4] = '{"abort_2nd",   16'h8181, 16'h4242, 12, 1};

    rst = 1'b1; SCK = 1'b0; SIMO = 1'b0; CS = 1'b1; data_out = 8'h00;
    model_data_in = 8'h00;
    wait_clk(3);
    check("rst_data_in", {24'h0, data_in}, 32'h0);
    check("rst_valid", {31'h0, data_valid}, 32'h0);
    check("rst_somi_hiz", {31'h0, somi_w}, 32'h1);
    rst = 1'b0;
    wait_clk(4);
    check("idle_somi_hiz", {31'h0, somi_w}, 32'h1);

    foreach (vecs[v]) begin
      frame(vecs[v].mosi, vecs[v].miso, vecs[v].nbits, 8'h00);
      check({vecs[v].name, "_pulses"}, got_q.size(), vecs[v].exp_pulses);
      drain(vecs[v].name);
    end

    // Deselected: SCK/SIMO activity must be ignored and SOMI released.
    begin
      int hiz_bad;
      hiz_bad = 0;
      for (int c = 0; c < 20; c++) begin
        SIMO = 1'($urandom);
        SCK  = 1'b1;
        wait_clk(2);
        if (somi_w !== 1'b1) hiz_bad++;
        SCK  = 1'b0;
        wait_clk(2);
        if (somi_w !== 1'b1) hiz_bad++;
      end
      check("desel_somi_hiz", hiz_bad, 0);
      drain("desel");
    end

    // Randomized frames, some aborted mid-byte.
    for (int r = 0; r < 16; r++) begin
      int          nb;
      logic [15:0] mo, mi;
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15))
                                       : 8 * int'($urandom_range(1, 2));
      mo = 16'($urandom);
      mi = 16'($urandom);
      frame(mo, mi, nb, 8'h00);
      drain("rand");
    end

    // Reset in the middle of a frame.
    @(negedge clk);
    CS = 1'b0;
    data_out = 8'hE7;
    wait_clk(8);
    for (int b = 0; b < 5; b++) begin
      SIMO = 1'b1;
      wait_clk(4);
      SCK = 1'b1;
      wait_clk(4);
      SCK = 1'b0;
    end
    wait_clk(1);
    rst = 1'b1;
    #1;
    check("midrst_data_in", {24'h0, data_in}, 32'h0);
    check("midrst_valid", {31'h0, data_valid}, 32'h0);
    check("midrst_somi_hiz", {31'h0, somi_w}, 32'h1);
    model_data_in = 8'h00;
    exp_q.delete();
    wait_clk(3);
    CS = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(8);
    drain("rst_abort");
    frame(16'h5A00, 16'h3C00, 8, 8'h00);
    drain("after_rst");

    check("valid_width", wide_pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_com.md
# spi_com

SPI slave (mode 0: CPOL=0, CPHA=0, MSB first, CS active-low) that connects an external SPI master to the FPGA's internal logic. All SPI pins are oversampled in the `clk` domain. Each completed 8-bit frame is delivered on `data_in` with a one-cycle strobe. The byte on `data_out` is shifted back to the master in the same frame.

## Interface
- `DATA_W`, default 8: frame width in bits; ports below use 8.
- `SYNC_STAGES`, default 2: flip-flop stages in each input synchronizer (minimum 2).
- `clk` input 1: system clock; one clock, all logic on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `SCK` input 1: SPI clock from the master, asynchronous to `clk`.
- `SIMO` input 1: serial data from the master.
- `CS` input 1: chip select, active-low.
- `SOMI` output 1: serial data to the master; high-Z while deselected.
- `data_in` output 8: last complete byte received.
- `data_valid` output 1: one-`clk` pulse when `data_in` updates.
- `data_out` input 8: byte to transmit; sampled at frame load points.

## Operation
- `SCK`, `CS` and `SIMO` each pass through `SYNC_STAGES` flops.
  - Edge detection runs on the synchronized `SCK` and `CS`.
  - `SIMO` is delayed equally, so sampling stays aligned with `SCK`.
- Selected means synchronized `CS` = 0. While deselected:
  - The bit counter is held at 0.
  - `SOMI` = Z.
  - `SCK` and `SIMO` activity is ignored.
- `CS` falling edge: `tx_shift` <= `data_out`; `SOMI` drives `tx_shift[7]`; bit counter = 0.
- `SCK` rising edge while selected: `rx_shift` <= {`rx_shift[6:0]`, SIMO_sync}; counter increments.
  - When the counter wraps 7->0, `data_in` <= the completed byte.
  - On the same cycle `data_valid` = 1 for exactly one `clk`.
- `SCK` falling edge while selected:
  - If counter = 0 (a byte just completed): `tx_shift` <= `data_out`, which supports back-to-back bytes.
  - Otherwise: `tx_shift` shifts left.
  - In both cases `SOMI` = `tx_shift[7]`.
- `CS` rising edge mid-byte aborts the frame:
  - The counter clears and the partial `rx_shift` is discarded.
  - No `data_valid` is produced; `data_in` keeps its old value.
- Reset values:
  - `data_in` = 8'h00, `data_valid` = 0, `SOMI` = Z.
  - Counter = 0, shift registers = 0, synchronizers = idle (SCK=0, CS=1).
- Reset asserted mid-frame: the frame is lost. After release, the block waits for a new `CS` falling edge.

## Timing
- Requirement: `clk` frequency ≥ 4 × `SCK` frequency, with `SCK` high and low each ≥ 2 `clk` periods.
- Pin-to-detection latency is `SYNC_STAGES` + 1 `clk` (3 at default).
- Master setup:
  - First `SCK` rise no earlier than 4 `clk` after `CS` falls.
  - `SOMI` is valid no later than 3 `clk` after `CS` falls.
- `data_valid` asserts 3 `clk` after the 8th `SCK` rising edge at the pin (default sync depth).
- `SOMI` changes 3 `clk` after each `SCK` falling edge at the pin. It is stable before the next rising edge.
- `data_out` must be stable from the last rising edge of the previous byte through the following falling edge.

## Structure
- Shared package `spi_pkg`:
  - `DATA_W` = 8, `SYNC_STAGES` = 2.
  - Bit-counter width `$clog2(DATA_W)`.
- Sub-module `spi_sync`:
  - Parameterized N-flop synchronizer with reset value input.
  - Optional rise/fall pulse outputs.
  - Instantiated three times: `SCK` (reset 0), `CS` (reset 1), `SIMO` (reset 0).
- Top `spi_com` holds the bit counter, `rx_shift`, `tx_shift`, the `data_in` register and the `SOMI` tri-state driver.

## Test plan
- Single byte: `data_out`=8'hBB; master sends 8'hA5 with SCK = `clk`/8.
  - `data_in`=8'hA5 with one `data_valid` pulse.
  - Master samples `SOMI` = 1,0,1,1,1,0,1,1.
- Back-to-back: 16 `SCK` cycles under one `CS` low; master sends 8'h3C then 8'hC3; `data_out` changes 8'h11->8'h22 between bytes.
  - Two `data_valid` pulses, `data_in` = 8'h3C then 8'hC3.
  - `SOMI` carries 8'h11 then 8'h22.
- Abort: `CS` rises after 4 bits of 8'hF0.
  - No `data_valid`; `data_in` unchanged.
  - Next full frame 8'h0F is received correctly.
- Deselected: `CS`=1, toggle `SCK`/`SIMO` for 20 cycles.
  - `SOMI`=Z, no `data_valid`, `data_in` unchanged.
- Reset mid-frame: assert `rst` after 5 bits.
  - Immediately `data_in`=8'h00, `data_valid`=0, `SOMI`=Z.
  - A new frame 8'h5A after release is received correctly.
